// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle core: memory-port FSM, access kinds
// and the main controller's state codes.
package mc_pkg;

    localparam int CNT_W       = 8;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mp_state_t;

    typedef enum logic [1:0] {
        ACC_FETCH = 2'd0,
        ACC_LOAD  = 2'd1,
        ACC_STORE = 2'd2
    } acc_kind_t;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } ctrl_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/mem_timeout_cnt.sv
// Counts REQ cycles; tc_o flags the cycle that is the TIMEOUT-th REQ cycle.
module mem_timeout_cnt
    import mc_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)     cnt_d = '0;
        else if (en_i) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // cnt_q holds the number of REQ cycles already completed.
    assign tc_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_ctrl.sv
// Unified I/D memory adapter: turns controller strobes into one req/ack
// transaction and stalls the core until it completes or times out.
module mem_port_ctrl
    import mc_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic [31:0] result,
    input  logic [31:0] wd,
    input  logic        ir_write,
    input  logic        adr_src,
    input  logic        mem_write,
    output logic        stall,
    output logic [31:0] instr,
    output logic [31:0] old_pc,
    output logic [31:0] mdr,
    output logic        misalign,
    output logic        bus_err,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack
);

    mp_state_t   state_q, state_d;
    acc_kind_t   kind_q, kind_d;
    logic [31:0] instr_q, instr_d, old_pc_q, old_pc_d, mdr_q, mdr_d;
    logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
    logic        misalign_q, misalign_d, bus_err_q, bus_err_d;
    logic        m_req_q, m_req_d, m_we_q, m_we_d;
    logic        fetch, load, store, access, tc;
    logic [31:0] addr_sel;

    assign fetch    = ir_write;
    assign load     = adr_src & ~mem_write & ~ir_write;
    assign store    = mem_write;
    assign access   = fetch | load | store;
    assign addr_sel = fetch ? pc : result;

    mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q != REQ),
        .en_i  (state_q == REQ),
        .tc_o  (tc)
    );

    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        instr_d    = instr_q;
        old_pc_d   = old_pc_q;
        mdr_d      = mdr_q;
        misalign_d = misalign_q;
        bus_err_d  = bus_err_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    // Fetch wins if the controller ever raises more than one strobe.
                    kind_d    = fetch ? ACC_FETCH : (store ? ACC_STORE : ACC_LOAD);
                    m_req_d   = 1'b1;
                    m_we_d    = store & ~fetch;
                    m_addr_d  = word_align(addr_sel);
                    m_wdata_d = wd;
                    if (addr_sel[1:0] != 2'b00) misalign_d = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (m_ack) begin
                    if (kind_q == ACC_FETCH) begin
                        instr_d  = m_rdata;
                        old_pc_d = m_addr_q;
                    end else if (kind_q == ACC_LOAD) begin
                        mdr_d = m_rdata;
                    end
                    m_req_d = 1'b0;
                    m_we_d  = 1'b0;
                    state_d = DONE;
                end else if (tc) begin
                    if (kind_q == ACC_FETCH)     instr_d = '0;
                    else if (kind_q == ACC_LOAD) mdr_d   = '0;
                    bus_err_d = 1'b1;
                    m_req_d   = 1'b0;
                    m_we_d    = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            kind_q     <= ACC_FETCH;
            instr_q    <= '0;
            old_pc_q   <= '0;
            mdr_q      <= '0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            instr_q    <= instr_d;
            old_pc_q   <= old_pc_d;
            mdr_q      <= mdr_d;
            misalign_q <= misalign_d;
            bus_err_q  <= bus_err_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
        end
    end

    assign stall    = ((state_q == IDLE) & access) | (state_q == REQ);
    assign instr    = instr_q;
    assign old_pc   = old_pc_q;
    assign mdr      = mdr_q;
    assign misalign = misalign_q;
    assign bus_err  = bus_err_q;
    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;

endmodule

// File: doc/mem_port_ctrl.md
# mem_port_ctrl

Unified instruction/data memory adapter for the multi-cycle RISC-V core. It sits directly downstream of the main controller and turns its strobes (IRWrite, AdrSrc, MemWrite) into one req/ack transaction on a variable-latency memory. It returns `stall` so the controller holds its state until the access completes. It owns the instruction register, OldPC and the memory data register (MDR).

## Interface
- TIMEOUT, 64: max cycles in REQ before the access is aborted; legal range 2..255
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- pc  in  32  current PC; fetch address
- result  in  32  datapath Result bus; load/store address
- wd  in  32  store data (register B)
- ir_write  in  1  controller: fetch access (IF state)
- adr_src  in  1  controller: data-address select
- mem_write  in  1  controller: store access
- stall  out  1  core must freeze its state register and qualify PCWrite/RegWrite/MemWrite with !stall
- instr  out  32  instruction register
- old_pc  out  32  PC of the instruction held in `instr`
- mdr  out  32  load data register
- misalign  out  1  sticky: an access had addr[1:0] != 0
- bus_err  out  1  sticky: an access timed out
- m_req  out  1  memory request, held until ack
- m_we  out  1  write qualifier, valid with m_req
- m_addr  out  32  word-aligned address, valid with m_req
- m_wdata  out  32  store data, valid with m_req
- m_rdata  in  32  read data, valid with m_ack
- m_ack  in  1  one-cycle completion pulse

## Operation
- Access decode (combinational):
  - fetch = ir_write
  - load = adr_src & !mem_write & !ir_write
  - store = mem_write
  - access = fetch | load | store
- Address: `pc` for fetch, `result` otherwise.
- FSM states: IDLE, REQ, DONE.
- IDLE, access=1:
  - latch kind (fetch/load/store), {addr[31:2],2'b00}, wd and raw addr.
  - Set misalign if addr[1:0] != 0; the access still proceeds.
  - Go to REQ.
- IDLE, access=0: remain in IDLE.
- REQ:
  - m_req=1; m_we=1 only for store.
  - On m_ack:
    - fetch: instr<=m_rdata, old_pc<=latched addr (aligned).
    - load: mdr<=m_rdata.
    - store: no capture.
    - Go to DONE.
  - Cycle counter: reaches TIMEOUT with no ack → drop m_req, set bus_err, instr/mdr<=0 for fetch/load, go to DONE.
- DONE: stall=0 for exactly one cycle, so the controller advances, then go to IDLE. A new access in the following cycle is accepted normally.
- stall = (IDLE & access) | REQ. It is 0 in DONE and in IDLE with no access.
- m_ack outside REQ is ignored.
- m_ack in the same cycle the timeout is reached counts as success. No bus_err is set.
- misalign and bus_err clear only on rst.
- Reset values (asynchronous), immediate even mid-transaction:
  - state=IDLE, counter=0
  - instr=0, old_pc=0, mdr=0, misalign=0, bus_err=0
  - m_req=0, m_we=0, m_addr=0, m_wdata=0
  - stall is a function of state and inputs, so it is 0 unless access=1.

## Timing
- m_req/m_we/m_addr/m_wdata are registered. They are asserted the cycle after the access is seen.
- They stay stable for the whole of REQ.
- Access seen at cycle t:
  - stall=1 at t.
  - m_req=1 from t+1.
  - ack at t+k (k≥1): captured at the end of t+k, stall=1 through t+k, DONE at t+k+1.
- Minimum latency: 2 stalled cycles per access. Stalled cycles = k+1.
- Timeout: the counter counts REQ cycles starting at 1. Abort takes effect at the edge ending REQ cycle TIMEOUT. Worst case is TIMEOUT+1 stalled cycles.
- instr/old_pc/mdr are visible in DONE (cycle t+k+1) and hold until the next capture.

## Structure
- Shared package `mc_pkg`: FSM state encoding (IDLE=2'd0, REQ=2'd1, DONE=2'd2) and access-kind encoding (FETCH, LOAD, STORE). The controller's state codes also belong in this package.
- One sub-module: `mem_timeout_cnt`, an 8-bit up-counter with clear and enable plus a terminal-count output compared against TIMEOUT.

## Test plan
- Fetch, pc=0x0000_0010, ack after 3 REQ cycles with rdata=0x0050_0093 → stall high 4 cycles, m_addr=0x10, m_we=0, instr=0x0050_0093, old_pc=0x10 in DONE.
- Load, result=0x0000_0104, ack at the first REQ cycle with rdata=0xDEAD_BEEF → 2 stalled cycles, mdr=0xDEAD_BEEF, instr unchanged.
- Store, result=0x0000_0200, wd=0x1234_5678 → m_we=1, m_wdata=0x1234_5678 held until ack; no capture; DONE 1 cycle later.
- Fetch, TIMEOUT=4, no ack → m_req drops after 4 REQ cycles, bus_err=1, instr=0, stall releases; bus_err stays 1 on the next good access.
- Load at result=0x0000_0102 → m_addr=0x100, misalign=1; spurious m_ack in IDLE is ignored.
- rst asserted in the middle of REQ → m_req=0, state IDLE, all registers 0 in the same cycle; a fresh fetch after rst completes normally.
